// File: rtl/mips_cpu_pkg.sv
// Shared MIPS CPU definitions: the sequencer state encoding used by both the
// sequencer and the control decoder, main-opcode constants and opcode helpers.
package mips_cpu_pkg;

  typedef enum logic [2:0] {
    StFetch     = 3'b000,
    StDecode    = 3'b001,
    StExecute   = 3'b010,
    StMemAccess = 3'b011,
    StWriteBack = 3'b100,
    StHalted    = 3'b101
  } state_t;

  localparam logic [5:0] OpSpecial = 6'h00;
  localparam logic [5:0] OpJ       = 6'h02;
  localparam logic [5:0] OpBeq     = 6'h04;
  localparam logic [5:0] OpAddiu   = 6'h09;
  localparam logic [5:0] OpAndi    = 6'h0c;
  localparam logic [5:0] OpLb      = 6'h20;
  localparam logic [5:0] OpLh      = 6'h21;
  localparam logic [5:0] OpLwl     = 6'h22;
  localparam logic [5:0] OpLw      = 6'h23;
  localparam logic [5:0] OpLbu     = 6'h24;
  localparam logic [5:0] OpLhu     = 6'h25;
  localparam logic [5:0] OpLwr     = 6'h26;
  localparam logic [5:0] OpSb      = 6'h28;
  localparam logic [5:0] OpSh      = 6'h29;
  localparam logic [5:0] OpSw      = 6'h2b;

  // Loads are the only instructions that need the WRITE_BACK cycle.
  function automatic logic is_load(logic [5:0] op);
    return op inside {OpLb, OpLh, OpLwl, OpLw, OpLbu, OpLhu, OpLwr};
  endfunction

endpackage

// File: rtl/mips_state_sequencer_if.sv
// Decoder/memory-side signals of the multicycle state sequencer.
interface mips_state_sequencer_if
  import mips_cpu_pkg::*;
#(
  parameter int unsigned COUNT_W = 32
) ();

  logic [5:0]         opcode;
  logic               mem_read;
  logic               mem_write;
  logic               waitrequest;
  logic [31:0]        pc_next;
  state_t             state;
  logic               stall;
  logic               instr_done;
  logic               active;
  logic [COUNT_W-1:0] instr_count;

  modport master (
    output opcode, mem_read, mem_write, waitrequest, pc_next,
    input  state, stall, instr_done, active, instr_count
  );

  modport slave (
    input  opcode, mem_read, mem_write, waitrequest, pc_next,
    output state, stall, instr_done, active, instr_count
  );

endinterface

// File: rtl/mips_state_sequencer.sv
// Multicycle MIPS state sequencer: FETCH..WRITE_BACK stepping with memory
// stalls, halt on a jump to address 0, and a retired-instruction counter.
module mips_state_sequencer
  import mips_cpu_pkg::*;
#(
  parameter int unsigned COUNT_W = 32
) (
  input logic                   clk,
  input logic                   reset,
  mips_state_sequencer_if.slave bus
);

  state_t             state_q, state_d;
  logic               active_q;
  logic [COUNT_W-1:0] instr_count_q;
  logic               stall;
  logic               last_st;
  logic               instr_done;

  always_comb begin
    stall      = (bus.mem_read | bus.mem_write) & bus.waitrequest & (state_q != StHalted);
    // opcode only matters here; the IR is stable from DECODE onward.
    last_st    = (state_q == StWriteBack) ||
                 ((state_q == StMemAccess) && !is_load(bus.opcode));
    instr_done = last_st & ~stall;
    state_d    = state_q;
    if (!stall) begin
      if (last_st) begin
        state_d = (bus.pc_next == 32'h0) ? StHalted : StFetch;
      end else begin
        case (state_q)
          StFetch:     state_d = StDecode;
          StDecode:    state_d = StExecute;
          StExecute:   state_d = StMemAccess;
          StMemAccess: state_d = StWriteBack;
          StHalted:    state_d = StHalted;
          default:     state_d = StFetch;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StFetch;
      active_q      <= 1'b1;
      instr_count_q <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= (state_d != StHalted);
      if (instr_done) begin
        instr_count_q <= instr_count_q + COUNT_W'(1);
      end
    end
  end

  assign bus.state       = state_q;
  assign bus.stall       = stall;
  assign bus.instr_done  = instr_done;
  assign bus.active      = active_q;
  assign bus.instr_count = instr_count_q;

endmodule

// File: tb/tb_mips_state_sequencer.sv
// Self-checking bench: directed vector table, hand sequences for halt/reset/wrap,
// then randomized stimulus against an instruction-level reference model.
module tb_mips_state_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic        mem_read;
  logic        mem_write;
  logic        waitrequest;
  logic [31:0] pc_next;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mips_state_sequencer_if #(.COUNT_W(32)) bus_w ();
  mips_state_sequencer_if #(.COUNT_W(4))  bus_n ();

  assign bus_w.opcode      = opcode;
  assign bus_w.mem_read    = mem_read;
  assign bus_w.mem_write   = mem_write;
  assign bus_w.waitrequest = waitrequest;
  assign bus_w.pc_next     = pc_next;
  assign bus_n.opcode      = opcode;
  assign bus_n.mem_read    = mem_read;
  assign bus_n.mem_write   = mem_write;
  assign bus_n.waitrequest = waitrequest;
  assign bus_n.pc_next     = pc_next;

  mips_state_sequencer #(.COUNT_W(32)) dut_w (.clk(clk), .reset(reset), .bus(bus_w));
  mips_state_sequencer #(.COUNT_W(4))  dut_n (.clk(clk), .reset(reset), .bus(bus_n));

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        mr;
    logic        mw;
    logic        wr;
    logic [31:0] pc;
    logic [2:0]  e_state;
    logic        e_stall;
    logic        e_done;
    logic        e_active;
    logic [31:0] e_count;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic [5:0] op, input logic mr, input logic mw,
                       input logic wr, input logic [31:0] pc);
    @(negedge clk);
    reset = rst; opcode = op; mem_read = mr; mem_write = mw; waitrequest = wr; pc_next = pc;
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [2:0] st, input logic stl,
                         input logic dn, input logic act, input logic [31:0] cnt);
    chk({tag, " state"},       32'(bus_w.state),      32'(st));
    chk({tag, " stall"},       32'(bus_w.stall),      32'(stl));
    chk({tag, " instr_done"},  32'(bus_w.instr_done), 32'(dn));
    chk({tag, " active"},      32'(bus_w.active),     32'(act));
    chk({tag, " count"},       bus_w.instr_count,     cnt);
    chk({tag, " state_n"},     32'(bus_n.state),      32'(st));
    chk({tag, " count_n"},     32'(bus_n.instr_count), cnt % 16);
  endtask

  function automatic vec_t v(input logic [5:0] op, input logic mr, input logic mw,
                             input logic wr, input logic [31:0] pc, input logic [2:0] st,
                             input logic stl, input logic dn, input logic act,
                             input logic [31:0] cnt);
    vec_t r;
    r.rst = 1'b0; r.op = op; r.mr = mr; r.mw = mw; r.wr = wr; r.pc = pc;
    r.e_state = st; r.e_stall = stl; r.e_done = dn; r.e_active = act; r.e_count = cnt;
    return r;
  endfunction

  // Reference model: step index within the current instruction, halt flag, retired count.
  int          m_k;
  bit          m_halted;
  int unsigned m_count;

  function automatic bit m_load(input logic [5:0] op);
    return (op >= 6'h20) && (op <= 6'h26);
  endfunction

  function automatic bit m_stall();
    return (mem_read || mem_write) && waitrequest && !m_halted;
  endfunction

  function automatic bit m_final();
    return !m_halted && (m_k == 4 || (m_k == 3 && !m_load(opcode)));
  endfunction

  task automatic m_edge();
    if (reset) begin
      m_k = 0; m_halted = 0; m_count = 0;
    end else if (!m_halted && !m_stall()) begin
      if (m_final()) begin
        m_count++;
        if (pc_next == 32'h0) m_halted = 1;
        else m_k = 0;
      end else begin
        m_k++;
      end
    end
  endtask

  logic [5:0] ops [15];
  logic [31:0] pc_r;

  initial begin
    ops = '{6'h00, 6'h09, 6'h0c, 6'h23, 6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h26,
            6'h2b, 6'h28, 6'h02, 6'h04, 6'h3f};

    // ADDIU, 4 cycles
    vecs.push_back(v(6'h09, 1, 0, 0, 32'hBFC00004, 0, 0, 0, 1, 0));
    vecs.push_back(v(6'h09, 0, 0, 0, 32'hBFC00004, 1, 0, 0, 1, 0));
    vecs.push_back(v(6'h09, 0, 0, 0, 32'hBFC00004, 2, 0, 0, 1, 0));
    vecs.push_back(v(6'h09, 0, 0, 0, 32'hBFC00004, 3, 0, 1, 1, 0));
    // LW, 5 cycles; pc_next==0 in FETCH must not halt, waitrequest without access ignored
    vecs.push_back(v(6'h23, 1, 0, 0, 32'h00000000, 0, 0, 0, 1, 1));
    vecs.push_back(v(6'h23, 0, 0, 1, 32'hBFC00008, 1, 0, 0, 1, 1));
    vecs.push_back(v(6'h23, 0, 0, 0, 32'hBFC00008, 2, 0, 0, 1, 1));
    vecs.push_back(v(6'h23, 1, 0, 0, 32'hBFC00008, 3, 0, 0, 1, 1));
    vecs.push_back(v(6'h23, 0, 0, 0, 32'hBFC00008, 4, 0, 1, 1, 1));
    // SW with 3 wait cycles in MEMORY_ACCESS
    vecs.push_back(v(6'h2b, 1, 0, 0, 32'hBFC0000C, 0, 0, 0, 1, 2));
    vecs.push_back(v(6'h2b, 0, 0, 0, 32'hBFC0000C, 1, 0, 0, 1, 2));
    vecs.push_back(v(6'h2b, 0, 0, 0, 32'hBFC0000C, 2, 0, 0, 1, 2));
    vecs.push_back(v(6'h2b, 0, 1, 1, 32'hBFC0000C, 3, 1, 0, 1, 2));
    vecs.push_back(v(6'h2b, 0, 1, 1, 32'hBFC0000C, 3, 1, 0, 1, 2));
    vecs.push_back(v(6'h2b, 0, 1, 1, 32'hBFC0000C, 3, 1, 0, 1, 2));
    vecs.push_back(v(6'h2b, 0, 1, 0, 32'hBFC0000C, 3, 0, 1, 1, 2));
    // JR to address 0 halts
    vecs.push_back(v(6'h00, 1, 0, 0, 32'h00400000, 0, 0, 0, 1, 3));
    vecs.push_back(v(6'h00, 0, 0, 0, 32'h00400000, 1, 0, 0, 1, 3));
    vecs.push_back(v(6'h00, 0, 0, 0, 32'h00400000, 2, 0, 0, 1, 3));
    vecs.push_back(v(6'h00, 0, 0, 0, 32'h00000000, 3, 0, 1, 1, 3));
    vecs.push_back(v(6'h23, 1, 0, 1, 32'h00000000, 5, 0, 0, 0, 4));

    drive(1, 6'h00, 0, 0, 0, 32'hBFC00000);
    @(posedge clk);
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].op, vecs[i].mr, vecs[i].mw, vecs[i].wr, vecs[i].pc);
      chk_all($sformatf("vec%0d", i), vecs[i].e_state, vecs[i].e_stall, vecs[i].e_done,
              vecs[i].e_active, vecs[i].e_count);
      @(posedge clk);
    end

    // HALTED absorbs 20 cycles of random activity
    for (int i = 0; i < 20; i++) begin
      drive(0, ops[$urandom_range(0, 14)], 1'($urandom), 1'($urandom), 1'($urandom),
            32'($urandom_range(0, 3)));
      chk_all("halted", 3'd5, 0, 0, 0, 4);
      @(posedge clk);
    end

    // Reset while halted
    drive(1, 6'h00, 1, 0, 1, 32'h0);
    @(posedge clk);
    drive(0, 6'h09, 1, 0, 0, 32'hBFC00004);
    chk_all("rst_halted", 3'd0, 0, 0, 1, 0);
    @(posedge clk);

    // Finish the ADDIU, then stall in FETCH and reset mid-stall
    for (int i = 0; i < 3; i++) begin
      drive(0, 6'h09, 0, 0, 0, 32'hBFC00004);
      @(posedge clk);
    end
    drive(0, 6'h09, 1, 0, 1, 32'hBFC00004);
    chk_all("fetch_stall", 3'd0, 1, 0, 1, 1);
    @(posedge clk);
    drive(1, 6'h09, 1, 0, 1, 32'hBFC00004);
    chk_all("fetch_stall2", 3'd0, 1, 0, 1, 1);
    @(posedge clk);
    drive(0, 6'h09, 1, 0, 0, 32'hBFC00004);
    chk_all("rst_stall", 3'd0, 0, 0, 1, 0);

    // 16 back-to-back ANDs: narrow counter wraps on the 16th
    for (int n = 1; n <= 16; n++) begin
      for (int c = 0; c < 4; c++) begin
        drive(0, 6'h00, c == 0, 0, 0, 32'h00400000 + 32'(n));
        @(posedge clk);
      end
      #1;
      chk($sformatf("wrap_n%0d", n), 32'(bus_n.instr_count), 32'(n % 16));
      chk($sformatf("wrap_w%0d", n), bus_w.instr_count, 32'(n));
    end

    // Randomized run against the reference model
    drive(1, 6'h00, 0, 0, 0, 32'h1);
    @(posedge clk);
    m_edge();
    for (int i = 0; i < 3000; i++) begin
      pc_r = ($urandom_range(0, 99) < 3) ? 32'h0 : $urandom;
      drive(($urandom_range(0, 199) == 0), ops[$urandom_range(0, 14)],
            1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 3), pc_r);
      chk_all($sformatf("rand%0d", i), m_halted ? 3'd5 : 3'(m_k), m_stall(),
              m_final() && !m_stall(), !m_halted, m_count);
      @(posedge clk);
      m_edge();
      if (m_halted && ($urandom_range(0, 7) == 0)) begin
        drive(1, 6'h00, 0, 0, 0, 32'h1);
        @(posedge clk);
        m_edge();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_state_sequencer.md
# mips_state_sequencer

Multicycle state sequencer for the MIPS CPU. It owns the registered 3-bit `state` that the combinational control decoder consumes, and advances it FETCH → DECODE → EXECUTE → MEMORY_ACCESS (→ WRITE_BACK for loads). It stalls on memory `waitrequest`, halts the core when an instruction hands control to address 0, and drives `active` plus a retired-instruction counter.

## Interface
Parameters:
- `COUNT_W`, 32: width of the retired-instruction counter.

Ports (clock and reset first):
- `clk`  in  1  core clock.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clk`.
- `opcode`  in  6  instruction bits [31:26], valid from DECODE onward.
- `mem_read`  in  1  decoder MemRead for the current state.
- `mem_write`  in  1  decoder MemWrite for the current state.
- `waitrequest`  in  1  memory not ready; current access must be held.
- `pc_next`  in  32  value the PC register will hold after this edge.
- `state`  out  3  current state, `state_t` encoding.
- `stall`  out  1  combinational; current state repeats next cycle, and the datapath gates all register writes.
- `instr_done`  out  1  combinational; high in the final state of an instruction when not stalled.
- `active`  out  1  registered; 1 while running, 0 once halted.
- `instr_count`  out  COUNT_W  registered count of retired instructions.

## Operation
- Encoding is fixed and shared with the decoder: FETCH=000, DECODE=001, EXECUTE=010, MEMORY_ACCESS=011, WRITE_BACK=100, HALTED=101. The decoder drives all-default controls for 101.
- `stall = (mem_read | mem_write) & waitrequest & (state != HALTED)`.
- When `stall` is high, `state` holds and no other register changes.
- Transitions when not stalled:
  - FETCH→DECODE; DECODE→EXECUTE; EXECUTE→MEMORY_ACCESS.
  - MEMORY_ACCESS→WRITE_BACK if `is_load(opcode)` (LB, LH, LWL, LW, LBU, LHU, LWR); otherwise this is the final state.
  - WRITE_BACK is always a final state.
- Final state: `instr_done`=1 and `instr_count` increments, wrapping modulo 2^COUNT_W. The next state is HALTED if `pc_next == 32'h0`, else FETCH.
- Unknown opcodes take the 4-state path. The sequencer does not trap on them.
- HALTED is absorbing. `active` drops to 0 on the same edge that enters HALTED. `stall` and `instr_done` are 0 in HALTED, and `waitrequest` is ignored.
- `opcode` is sampled only in MEMORY_ACCESS. It must be stable from DECODE, because the IR is loaded in DECODE.

## Timing
- Reset values: `state`=FETCH, `active`=1, `instr_count`=0.
- `stall` and `instr_done` are combinational from `state` and inputs. The reset has no effect on them beyond driving `state`.
- Reset wins over every other event, including a stall, HALTED, or a final-state edge. The next cycle is FETCH with the count cleared.
- Non-load instruction: 4 cycles. Load: 5 cycles. Each cycle with `stall` high adds 1 cycle.
- `waitrequest` high in a state with no memory access has no effect.
- Simultaneous final state, `pc_next==0`, and counter at max: count wraps to 0, state becomes HALTED, `active` becomes 0. All three happen on the same edge.
- A `pc_next==0` in a non-final state (e.g. the FETCH PC+4 write) does not halt.
- No combinational path from `waitrequest` to `state` without passing through a register.

## Structure
- Shared package `mips_cpu_pkg`:
  - `state_t`, including HALTED, replacing the decoder-local enum.
  - Opcode constants.
  - `function is_load(logic [5:0] op)`.
- No sub-module. A single always_ff for state, `active` and the counter, plus an always_comb for next-state, `stall` and `instr_done`.

## Test plan
- ADDIU with `waitrequest`=0, `pc_next`=0xBFC00004 → states 0,1,2,3,0; `instr_done` pulses once in MEMORY_ACCESS; `instr_count`=1.
- LW → states 0,1,2,3,4,0; `instr_done` only in WRITE_BACK.
- SW with `waitrequest` high for 3 cycles in MEMORY_ACCESS → MEMORY_ACCESS held 4 cycles with `stall`=1 for 3; the count increments once.
- JR whose final state has `pc_next`=0 → next state 101, `active`=0. It stays there for 20 cycles despite toggling `waitrequest` and opcode.
- `reset` asserted while HALTED, and separately mid-stall in FETCH → next cycle `state`=FETCH, `active`=1, `instr_count`=0.
- COUNT_W=4 with 16 back-to-back ANDs → `instr_count` wraps 15→0 on the 16th `instr_done`.
